// File: rtl/ssq_sched_pkg.sv
// Shared types and sizes for the slave-select queue sequencer.
package ssq_sched_pkg;
   localparam int QUEUE_DEPTH = 16;
   localparam int ADDR_W      = 8;
   localparam int LEVEL_W     = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LATCH = 3'd2,
      SETUP = 3'd3,
      START = 3'd4,
      XFER  = 3'd5,
      HOLD  = 3'd6,
      GAP   = 3'd7
   } state_t;
endpackage

// File: rtl/ss_decoder.sv
// Slave address plus enable to active-low one-hot select (combinational).
module ss_decoder
   import ssq_sched_pkg::*;
#(
   parameter int NUM_SLAVES = 8
) (
   input  logic [ADDR_W-1:0]     cur_addr,
   input  logic                  en,
   output logic [NUM_SLAVES-1:0] ss_n
);
   localparam int SEL_W = $clog2(NUM_SLAVES);
   localparam logic [ADDR_W-1:0] SEL_MASK = ADDR_W'((1 << SEL_W) - 1);

   // Addresses wrap on the select width; for non-power-of-2 counts the
   // unused codes match no line, leaving every select high.
   logic [ADDR_W-1:0] idx;
   assign idx = cur_addr & SEL_MASK;

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
      assign ss_n[i] = ~(en && (idx == ADDR_W'(i)));
   end
endmodule

// File: rtl/ssq_scheduler.sv
// Slave-select queue sequencer: pushes requests into the SSQ, pops them in order and frames
// each SPI transfer with ss_n. Define SSQ_SCHED_RANGE_CHECK_EN to drop out-of-range requests.
module ssq_scheduler
   import ssq_sched_pkg::*;
#(
   parameter int NUM_SLAVES   = 8,
   parameter int SETUP_CYCLES = 2,
   parameter int HOLD_CYCLES  = 2,
   parameter int GAP_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  req_ready,
   output logic                  req_err,
   output logic                  ssq_wr_en,
   output logic [ADDR_W-1:0]     ssq_wr_addr,
   output logic                  ssq_rd_en,
   input  logic [ADDR_W-1:0]     ssq_rd_addr,
   output logic                  spi_start,
   input  logic                  spi_done,
   output logic [NUM_SLAVES-1:0] ss_n,
   output logic                  busy,
   output logic [LEVEL_W-1:0]    level
);
   state_t                  state, state_nxt;
   logic [7:0]              cnt;
   logic [ADDR_W-1:0]       cur_addr, cur_addr_nxt;
   logic                    hs, push, pop, sel_en;
   logic [NUM_SLAVES-1:0]   ss_n_nxt;

   assign req_ready = (level < LEVEL_W'(QUEUE_DEPTH));
   assign hs        = req_valid && req_ready;

`ifdef SSQ_SCHED_RANGE_CHECK_EN
   logic in_range;
   assign in_range = ({1'b0, req_addr} < 9'(NUM_SLAVES));
   assign push     = hs && in_range;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) req_err <= 1'b0;
      else         req_err <= hs && !in_range;
   end
`else
   assign push    = hs;
   assign req_err = 1'b0;
`endif

   // A push in the same cycle always defers the pop, so the SSQ never
   // sees a read and write together.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (level != '0 && !push) state_nxt = POP;
         POP:     state_nxt = LATCH;
         LATCH:   state_nxt = SETUP;
         SETUP:   if (cnt == 8'(SETUP_CYCLES - 1)) state_nxt = START;
         START:   state_nxt = XFER;
         XFER:    if (spi_done) state_nxt = HOLD;
         HOLD:    if (cnt == 8'(HOLD_CYCLES - 1)) state_nxt = GAP;
         GAP:     if (cnt == 8'(GAP_CYCLES - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign pop          = (state == IDLE) && (state_nxt == POP);
   assign cur_addr_nxt = (state == LATCH) ? ssq_rd_addr : cur_addr;
   assign sel_en       = (state_nxt == SETUP) || (state_nxt == START) ||
                         (state_nxt == XFER)  || (state_nxt == HOLD);

   // Decode from the next address/state so ss_n falls on the edge entering SETUP.
   ss_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
      .cur_addr (cur_addr_nxt),
      .en       (sel_en),
      .ss_n     (ss_n_nxt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         cur_addr    <= '0;
         ss_n        <= '1;
         spi_start   <= 1'b0;
         ssq_rd_en   <= 1'b0;
         ssq_wr_en   <= 1'b0;
         ssq_wr_addr <= '0;
         busy        <= 1'b0;
         level       <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
         cur_addr  <= cur_addr_nxt;
         ss_n      <= ss_n_nxt;
         spi_start <= (state_nxt == START);
         ssq_rd_en <= pop;
         busy      <= (state_nxt != IDLE);
         ssq_wr_en <= push;
         if (push) ssq_wr_addr <= req_addr;
         if (push)     level <= level + LEVEL_W'(1);
         else if (pop) level <= level - LEVEL_W'(1);
      end
   end
endmodule

// File: tb/tb_ssq_scheduler.sv
// Self-checking bench for ssq_scheduler: models the SSQ and the SPI engine, checks ordering and framing.
module tb_ssq_scheduler;
   localparam int NS = 8, SU = 2, HO = 2, GP = 4, LIM = 3000;

   logic          clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, spi_done = 1'b0;
   logic [7:0]    req_addr = 8'd0, ssq_rd_addr = 8'd0;
   logic          req_ready, req_err, ssq_wr_en, ssq_rd_en, spi_start, busy;
   logic [7:0]    ssq_wr_addr;
   logic [NS-1:0] ss_n;
   logic [4:0]    level;

   int checks = 0, errors = 0;

   // Environment state: SSQ contents, SPI engine, and event logs.
   logic [7:0] ssq[$];
   int started[$], windows[$], lens[$];
   int overlap = 0, ssq_viol = 0, gap_viol = 0;
   int eng_cnt = 0, xfer_len = 10, inj_req = 0, inj_ack = 0;
   int run = 0, hrun = 0;
   bit eng_stall = 1'b0, rand_len = 1'b0, seen_win = 1'b0;

   ssq_scheduler #(.NUM_SLAVES(NS), .SETUP_CYCLES(SU), .HOLD_CYCLES(HO), .GAP_CYCLES(GP)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .req_err(req_err), .ssq_wr_en(ssq_wr_en),
      .ssq_wr_addr(ssq_wr_addr), .ssq_rd_en(ssq_rd_en), .ssq_rd_addr(ssq_rd_addr),
      .spi_start(spi_start), .spi_done(spi_done), .ss_n(ss_n), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   function automatic int sel_index(input logic [NS-1:0] v);
      sel_index = -1;
      for (int i = 0; i < NS; i++) if (!v[i]) sel_index = i;
   endfunction

   always @(posedge clk) begin : mon
      int xl;
      #2;
      if (!resetn) begin
         ssq.delete(); eng_cnt = 0; spi_done = 1'b0; run = 0; hrun = 0; seen_win = 1'b0;
         inj_ack = inj_req;
      end else begin
         spi_done = 1'b0;
         if (inj_req != inj_ack) begin spi_done = 1'b1; inj_ack = inj_req; end
         if (eng_cnt > 0 && !eng_stall) begin
            eng_cnt--;
            if (eng_cnt == 0) spi_done = 1'b1;
         end
         if (spi_start) begin
            xl = rand_len ? int'($urandom_range(1, 6)) : xfer_len;
            eng_cnt = xl;
            lens.push_back(xl);
            started.push_back(sel_index(ss_n));
         end
         if (ssq_wr_en && ssq_rd_en) overlap++;
         if (ssq_wr_en) begin
            if (ssq.size() >= 16) ssq_viol++; else ssq.push_back(ssq_wr_addr);
         end
         if (ssq_rd_en) begin
            if (ssq.size() == 0) ssq_viol++; else ssq_rd_addr = ssq.pop_front();
         end
         if (ss_n != '1) begin
            if (run == 0 && seen_win && hrun < GP) gap_viol++;
            run++; hrun = 0;
         end else begin
            if (run > 0) begin windows.push_back(run); run = 0; seen_win = 1'b1; end
            hrun++;
         end
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      while ((busy !== 1'b0 || level !== 5'd0) && n < LIM) begin @(negedge clk); n++; end
   endtask

   task automatic test_reset();
      resetn = 1'b0; req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ss_n !== '1) begin errors++; $display("FAIL reset_ss_n got %b exp all ones", ss_n); end
      checks++;
      if ({req_ready, req_err, ssq_wr_en, ssq_rd_en, spi_start, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl got rdy/err/wr/rd/start/busy=%b exp 100000",
                  {req_ready, req_err, ssq_wr_en, ssq_rd_en, spi_start, busy});
      end
      checks++; if (ssq_wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h exp 00", ssq_wr_addr); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
      @(negedge clk); resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int n, low, gap, b0;
      b0 = started.size(); xfer_len = 10;
      @(negedge clk); req_valid = 1'b1; req_addr = 8'd3;
      @(negedge clk); req_valid = 1'b0;
      checks++;
      if (ssq_wr_en !== 1'b1 || busy !== 1'b0 || ssq_wr_addr !== 8'd3 || level !== 5'd1) begin
         errors++;
         $display("FAIL single_push got wr_en=%b busy=%b addr=%0d level=%0d exp 1 0 3 1",
                  ssq_wr_en, busy, ssq_wr_addr, level);
      end
      n = 1; low = 0;
      while (spi_start !== 1'b1 && n < 40) begin
         if (ss_n === 8'b1111_0111) low++;
         @(negedge clk); n++;
      end
      checks++; if (n != 4 + SU) begin errors++; $display("FAIL single_latency got %0d exp %0d", n, 4 + SU); end
      checks++; if (low != SU) begin errors++; $display("FAIL single_setup got %0d exp %0d", low, SU); end
      low = 0;
      while (ss_n === 8'b1111_0111 && low < 40) begin @(negedge clk); low++; end
      checks++; if (low != 1 + 10 + HO) begin errors++; $display("FAIL single_sel_after_start got %0d exp %0d", low, 1 + 10 + HO); end
      gap = 0;
      while (busy === 1'b1 && ss_n === '1 && gap < 40) begin @(negedge clk); gap++; end
      checks++;
      if (gap != GP || busy !== 1'b0) begin errors++; $display("FAIL single_gap got %0d busy=%b exp %0d 0", gap, busy, GP); end
      checks++;
      if (started.size() != b0 + 1 || started[b0] != 3) begin
         errors++; $display("FAIL single_order got n=%0d exp one transfer to 3", started.size() - b0);
      end
   endtask

   task automatic test_full();
      logic [7:0] exp[$];
      logic [7:0] a;
      int b0, n, bad;
      b0 = started.size(); eng_stall = 1'b1; xfer_len = 2;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); a = 8'($urandom_range(0, NS - 1));
         req_valid = 1'b1; req_addr = a; exp.push_back(a);
      end
      @(negedge clk); a = 8'($urandom_range(0, NS - 1)); req_addr = a;
      checks++;
      if (level !== 5'd16 || req_ready !== 1'b0) begin
         errors++; $display("FAIL full_level got %0d rdy=%b exp 16 0", level, req_ready);
      end
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 1 || level !== 5'd15) begin errors++; $display("FAIL full_pop got wait=%0d level=%0d exp 1 15", n, level); end
      exp.push_back(a);
      @(negedge clk); req_valid = 1'b0;
      checks++;
      if (level !== 5'd16 || ssq_wr_en !== 1'b1 || ssq_wr_addr !== a) begin
         errors++; $display("FAIL full_17th got level=%0d wr=%b addr=%0d exp 16 1 %0d", level, ssq_wr_en, ssq_wr_addr, a);
      end
      repeat (10) @(negedge clk);
      eng_stall = 1'b0;
      wait_idle(n);
      checks++; if (n >= LIM) begin errors++; $display("FAIL full_drain timeout after %0d cycles", n); end
      bad = (started.size() != b0 + 17) ? 1 : 0;
      for (int k = 0; k < 17 && bad == 0; k++) if (started[b0 + k] != int'(exp[k])) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_order got %0d transfers exp 17 in push order", started.size() - b0); end
   endtask

   task automatic test_defer();
      int b0, ov0, n;
      b0 = started.size(); ov0 = overlap; xfer_len = 3;
      @(negedge clk); req_valid = 1'b1; req_addr = 8'd1;
      @(negedge clk); req_addr = 8'd5;
      @(negedge clk); req_valid = 1'b0;
      checks++;
      if (ssq_wr_en !== 1'b1 || ssq_rd_en !== 1'b0 || level !== 5'd2) begin
         errors++; $display("FAIL defer_push got wr=%b rd=%b level=%0d exp 1 0 2", ssq_wr_en, ssq_rd_en, level);
      end
      @(negedge clk);
      checks++;
      if (ssq_rd_en !== 1'b1 || ssq_wr_en !== 1'b0 || level !== 5'd1) begin
         errors++; $display("FAIL defer_pop got rd=%b wr=%b level=%0d exp 1 0 1", ssq_rd_en, ssq_wr_en, level);
      end
      wait_idle(n);
      checks++;
      if (n >= LIM || started.size() != b0 + 2 || started[b0] != 1 || started[b0 + 1] != 5) begin
         errors++; $display("FAIL defer_order got %0d transfers exp 1 then 5", started.size() - b0);
      end
      checks++; if (overlap != ov0) begin errors++; $display("FAIL defer_overlap got %0d exp %0d", overlap, ov0); end
   endtask

   task automatic test_reset_mid();
      int n, b0, spur;
      eng_stall = 1'b1; xfer_len = 3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); req_valid = 1'b1; req_addr = 8'($urandom_range(0, NS - 1));
      end
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (spi_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      checks++;
      if (level !== 5'd3 || busy !== 1'b1 || ss_n === '1) begin
         errors++; $display("FAIL rstmid_pre got level=%0d busy=%b ss_n=%b exp 3 1 selected", level, busy, ss_n);
      end
      resetn = 1'b0; #1;
      checks++;
      if (ss_n !== '1 || level !== 5'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got ss_n=%b level=%0d busy=%b exp ones 0 0", ss_n, level, busy);
      end
      @(negedge clk); resetn = 1'b1; eng_stall = 1'b0;
      b0 = started.size(); spur = 0;
      repeat (30) begin @(negedge clk); if (spi_start || ssq_rd_en || busy) spur++; end
      checks++;
      if (spur != 0 || started.size() != b0) begin errors++; $display("FAIL rstmid_spurious got %0d active cycles exp 0", spur); end
   endtask

   task automatic test_range();
      int n, b0;
      b0 = started.size(); xfer_len = 2;
      @(negedge clk); req_valid = 1'b1; req_addr = 8'd9;
      @(negedge clk); req_valid = 1'b0;
`ifdef SSQ_SCHED_RANGE_CHECK_EN
      checks++;
      if (req_err !== 1'b1 || ssq_wr_en !== 1'b0 || level !== 5'd0) begin
         errors++; $display("FAIL range_drop got err=%b wr=%b level=%0d exp 1 0 0", req_err, ssq_wr_en, level);
      end
      @(negedge clk);
      checks++;
      if (req_err !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL range_after got err=%b level=%0d busy=%b exp 0 0 0", req_err, level, busy);
      end
`else
      checks++;
      if (req_err !== 1'b0 || ssq_wr_en !== 1'b1 || ssq_wr_addr !== 8'd9 || level !== 5'd1) begin
         errors++; $display("FAIL range_push got err=%b wr=%b addr=%0d level=%0d exp 0 1 9 1", req_err, ssq_wr_en, ssq_wr_addr, level);
      end
      n = 0;
      while (spi_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (ss_n !== 8'b1111_1101) begin errors++; $display("FAIL range_sel got %b exp 11111101", ss_n); end
`endif
      wait_idle(n);
      checks++; if (n >= LIM) begin errors++; $display("FAIL range_drain timeout after %0d cycles", n); end
   endtask

   task automatic test_spurious();
      int n, low;
      xfer_len = 5;
      @(negedge clk); req_valid = 1'b1; req_addr = 8'd6;
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (ss_n === '1 && n < 20) begin @(negedge clk); n++; end
      inj_req++;
      n = 0;
      while (spi_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (spi_start !== 1'b1) begin errors++; $display("FAIL spur_start got %b exp 1", spi_start); end
      low = 0;
      while (ss_n === 8'b1011_1111 && low < 40) begin @(negedge clk); low++; end
      checks++; if (low != 1 + 5 + HO) begin errors++; $display("FAIL spur_window got %0d exp %0d", low, 1 + 5 + HO); end
      wait_idle(n);
      checks++; if (n >= LIM) begin errors++; $display("FAIL spur_drain timeout after %0d cycles", n); end
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      logic [7:0] a;
      bit v;
      int b0, w0, l0, gv0, ov0, sv0, lvl_bad, bad, n;
      b0 = started.size(); w0 = windows.size(); l0 = lens.size();
      gv0 = gap_viol; ov0 = overlap; sv0 = ssq_viol; lvl_bad = 0;
      rand_len = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (int'(level) != ssq.size() || req_ready !== (ssq.size() < 16)) lvl_bad++;
         v = ($urandom_range(0, 3) == 0);
         a = 8'($urandom_range(0, NS - 1));
         req_valid = v; req_addr = a;
         if (v && req_ready) exp.push_back(a);
      end
      @(negedge clk); req_valid = 1'b0;
      wait_idle(n);
      rand_len = 1'b0;
      checks++; if (n >= LIM) begin errors++; $display("FAIL rand_drain timeout after %0d cycles", n); end
      checks++; if (lvl_bad != 0) begin errors++; $display("FAIL rand_level got %0d bad cycles exp 0", lvl_bad); end
      bad = (started.size() - b0 != exp.size()) ? 1 : 0;
      for (int k = 0; k < exp.size() && bad == 0; k++) if (started[b0 + k] != int'(exp[k])) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d transfers exp %0d in push order", started.size() - b0, exp.size()); end
      bad = (windows.size() - w0 != lens.size() - l0) ? 1 : 0;
      for (int k = 0; k < lens.size() - l0 && bad == 0; k++)
         if (windows[w0 + k] != SU + 1 + lens[l0 + k] + HO) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_window got %0d windows with bad length exp 0", bad); end
      checks++;
      if (overlap != ov0 || ssq_viol != sv0 || gap_viol != gv0) begin
         errors++; $display("FAIL rand_protocol got overlap=%0d ssq=%0d gap=%0d exp %0d %0d %0d",
                            overlap, ssq_viol, gap_viol, ov0, sv0, gv0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_defer();
      test_reset_mid();
      test_range();
      test_spurious();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end
endmodule
